wm_phase_timer: RTL
===================

// Module: wm_phase_timer
// PURPOSE
//  Phase-duration timer for the washing-machine controller; sits directly downstream of
//  the control FSM. Consumes crnt_state and mode, loads that phase's duration, counts it
//  down on a prescaled tick, and returns timer_done to the FSM. Also produces the
//  idle auto-off timeout that moves the FSM from IDLE to SLEEP.
// PARAMETERS
//  TICK_DIV  10  clk cycles per time unit (tick); must be >= 1
//  CNT_W     8   width of the remaining-time counter
//  IDLE_TO   20  ticks spent in IDLE before idle_timeout fires
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  crnt_state    in   4      FSM state code
//  mode          in   3      wash programme select
//  pause_active  in   1      level; 1 = freeze counting
//  timer_done    out  1      one-cycle pulse: current phase duration elapsed
//  idle_timeout  out  1      one-cycle pulse: IDLE_TO ticks spent in IDLE
//  remaining     out  CNT_W  ticks left in the current phase
//  phase_busy    out  1      1 while a timed phase is counting or held
// BEHAVIOUR
//  State codes: 0000 OFF, 0001 IDLE, 0010 FILL, 0011 WASH, 0100 DRAIN, 0101 RINSE,
//   0110 SPIN, 0111 DONE, 1000 SLEEP. 1001-1111 are invalid and treated as untimed.
//  Timed phases: FILL, WASH, DRAIN, RINSE, SPIN.
//  Duration table (ticks, fill/wash/drain/rinse/spin):
//   m0 normal 4/8/3/6/5; m1 quick 2/4/2/3/3; m2 heavy 5/12/3/8/6;
//   m3 delicate 4/6/3/5/2; m4 rinse+spin 4/0/3/6/5; m5 spin-only 0/0/2/0/5.
//   m6 and m7 map to m0.
//  Reset (rst=0, any time): all outputs 0, internal FSM in T_IDLE, prescaler 0,
//   prev_state register set to 0000.
//  Change detection: prev_state is registered every cycle. A change is
//   crnt_state != prev_state.
//  Internal FSM: T_IDLE -> T_RUN -> T_EXPIRED; T_RUN <-> T_HOLD.
//   - Change to a timed phase, from any internal state: remaining <= table[mode][phase]
//     on the next edge, prescaler cleared, go to T_RUN. mode is sampled only at this
//     load; later mode changes have no effect until the next load.
//   - T_RUN: prescaler counts 0..TICK_DIV-1. At the wrap, remaining decrements. When
//     remaining goes 1->0, timer_done pulses in that same cycle and the FSM goes to
//     T_EXPIRED.
//   - Loaded duration 0: timer_done pulses on the cycle after the load, then T_EXPIRED.
//   - Latency for duration D: timer_done is high D*TICK_DIV+1 cycles after the cycle in
//     which the change is first visible.
//   - T_HOLD, entered while pause_active=1: prescaler and remaining frozen. When
//     pause_active=0, return to T_RUN and resume from the frozen prescaler value. No
//     reload.
//   - T_EXPIRED: remaining=0, no further pulses until crnt_state changes.
//   - Change to an untimed code: T_IDLE, remaining=0, phase_busy=0.
//   - phase_busy=1 in T_RUN and T_HOLD only.
//  Simultaneous events:
//   - A state change in the same cycle as a tick or expiry: the reload wins and no
//     pulse is issued for the old phase.
//   - pause_active in the same cycle as a load: the load happens, then the FSM holds.
//  Idle auto-off:
//   - While crnt_state==IDLE, count ticks. After IDLE_TO ticks, idle_timeout pulses once.
//   - Leaving IDLE, or any change, clears the count. The count does not re-arm until
//     IDLE is re-entered.
//   - pause_active does not affect the idle count.
//  Width: remaining saturates at 0 and never wraps. The table values must fit in CNT_W;
//   this is an elaboration check.
// STRUCTURE
//  wm_pkg (shared with FSM): state-code localparams, mode codes, and the
//   function phase_ticks(mode, state) returning the duration table.
//  Sub-module wm_tick_prescaler: counter 0..TICK_DIV-1 with clear and enable inputs;
//   produces a single-cycle tick.
//  Top module: change detector, internal FSM, remaining counter, idle counter.
// TESTING
//  1. TICK_DIV=10, mode=0, state 0001->0010 -> remaining=4, timer_done high 41 cycles
//     later for exactly 1 cycle.
//  2. mode=5, state->0011 (WASH, 0 ticks) -> timer_done on the 2nd cycle; remaining=0;
//     no second pulse while state is held.
//  3. mode=2, WASH, pause_active=1 for 37 cycles mid-count -> done is delayed by exactly
//     37 cycles; remaining is frozen during the pause.
//  4. WASH running, state->0100 on a tick cycle -> no done pulse; remaining=3 (mode 0)
//     on the next cycle.
//  5. State held at 0001 -> idle_timeout pulses once after 200 cycles. Leaving IDLE and
//     re-entering restarts the full 200.
//  6. rst low mid-RINSE, mode=7 (maps to m0) -> outputs 0 immediately. After release,
//     re-entry to 0101 loads 6.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washer definitions: state codes, programme codes and the per-phase
// duration table used by both the control FSM and the phase timer.
package wm_pkg;

  localparam logic [3:0] ST_OFF   = 4'h0;
  localparam logic [3:0] ST_IDLE  = 4'h1;
  localparam logic [3:0] ST_FILL  = 4'h2;
  localparam logic [3:0] ST_WASH  = 4'h3;
  localparam logic [3:0] ST_DRAIN = 4'h4;
  localparam logic [3:0] ST_RINSE = 4'h5;
  localparam logic [3:0] ST_SPIN  = 4'h6;
  localparam logic [3:0] ST_DONE  = 4'h7;
  localparam logic [3:0] ST_SLEEP = 4'h8;

  localparam logic [2:0] MODE_NORMAL     = 3'd0;
  localparam logic [2:0] MODE_QUICK      = 3'd1;
  localparam logic [2:0] MODE_HEAVY      = 3'd2;
  localparam logic [2:0] MODE_DELICATE   = 3'd3;
  localparam logic [2:0] MODE_RINSE_SPIN = 3'd4;
  localparam logic [2:0] MODE_SPIN_ONLY  = 3'd5;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_HOLD, T_EXPIRED} tstate_t;

  function automatic logic is_timed(input logic [3:0] state);
    return (state >= ST_FILL) && (state <= ST_SPIN);
  endfunction

  // Unlisted programmes (6, 7) fall back to the normal programme.
  function automatic logic [7:0] phase_ticks(input logic [2:0] mode, input logic [3:0] state);
    logic [7:0] fill, wash, drain, rinse, spin;
    case (mode)
      MODE_QUICK:      {fill, wash, drain, rinse, spin} = {8'd2, 8'd4,  8'd2, 8'd3, 8'd3};
      MODE_HEAVY:      {fill, wash, drain, rinse, spin} = {8'd5, 8'd12, 8'd3, 8'd8, 8'd6};
      MODE_DELICATE:   {fill, wash, drain, rinse, spin} = {8'd4, 8'd6,  8'd3, 8'd5, 8'd2};
      MODE_RINSE_SPIN: {fill, wash, drain, rinse, spin} = {8'd4, 8'd0,  8'd3, 8'd6, 8'd5};
      MODE_SPIN_ONLY:  {fill, wash, drain, rinse, spin} = {8'd0, 8'd0,  8'd2, 8'd0, 8'd5};
      default:         {fill, wash, drain, rinse, spin} = {8'd4, 8'd8,  8'd3, 8'd6, 8'd5};
    endcase
    case (state)
      ST_FILL:  return fill;
      ST_WASH:  return wash;
      ST_DRAIN: return drain;
      ST_RINSE: return rinse;
      ST_SPIN:  return spin;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic int max_phase_ticks();
    int m = 0;
    for (int md = 0; md < 8; md++) begin
      for (int st = int'(ST_FILL); st <= int'(ST_SPIN); st++) begin
        if (int'(phase_ticks(3'(md), 4'(st))) > m) m = int'(phase_ticks(3'(md), 4'(st)));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Free-running divider 0..TICK_DIV-1; tick is high for one enabled cycle at the wrap.
module wm_tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase-duration timer: reloads on every FSM state change, counts the phase down in
// prescaled ticks, and also times the IDLE auto-off.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 8,
  parameter int IDLE_TO  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       crnt_state,
  input  logic [2:0]       mode,
  input  logic             pause_active,
  output logic             timer_done,
  output logic             idle_timeout,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_busy
);

  localparam int IW = (IDLE_TO > 1) ? $clog2(IDLE_TO + 1) : 1;

  if (TICK_DIV < 1) begin : g_bad_div
    $error("wm_phase_timer: TICK_DIV must be at least 1");
  end
  if (max_phase_ticks() > (2 ** CNT_W) - 1) begin : g_bad_width
    $error("wm_phase_timer: duration table does not fit in CNT_W bits");
  end

  logic [3:0]       prev_state;
  logic             change;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             run_en;
  logic             tick;
  tstate_t          tstate, tstate_nxt;
  logic [CNT_W-1:0] remaining_nxt;
  logic             done_nxt;

  logic             idle_en;
  logic             idle_tick;
  logic             idle_fired;
  logic [IW-1:0]    idle_cnt;

  assign change     = (crnt_state != prev_state);
  assign load       = change && is_timed(crnt_state);
  assign load_val   = CNT_W'(phase_ticks(mode, crnt_state));
  assign run_en     = ((tstate == T_RUN) || (tstate == T_HOLD)) && !pause_active && !change;
  assign phase_busy = (tstate == T_RUN) || (tstate == T_HOLD);
  assign idle_en    = (crnt_state == ST_IDLE) && !change && !idle_fired;

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_phase_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (change),
    .enable (run_en),
    .tick   (tick)
  );

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_idle_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (change),
    .enable (idle_en),
    .tick   (idle_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state <= ST_OFF;
      tstate     <= T_IDLE;
      remaining  <= '0;
      timer_done <= 1'b0;
    end else begin
      prev_state <= crnt_state;
      tstate     <= tstate_nxt;
      remaining  <= remaining_nxt;
      timer_done <= done_nxt;
    end
  end

  // A state change always wins over a tick or expiry of the old phase.
  always_comb begin
    tstate_nxt    = tstate;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    if (change) begin
      if (load) begin
        remaining_nxt = load_val;
        if (load_val == '0) begin
          done_nxt   = 1'b1;
          tstate_nxt = T_EXPIRED;
        end else begin
          tstate_nxt = pause_active ? T_HOLD : T_RUN;
        end
      end else begin
        tstate_nxt    = T_IDLE;
        remaining_nxt = '0;
      end
    end else begin
      case (tstate)
        T_RUN, T_HOLD: begin
          tstate_nxt = pause_active ? T_HOLD : T_RUN;
          if (tick && (remaining != '0)) begin
            remaining_nxt = remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              done_nxt   = 1'b1;
              tstate_nxt = T_EXPIRED;
            end
          end
        end
        default: remaining_nxt = '0;
      endcase
    end
  end

  // One timeout per visit to IDLE; only a state change re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt     <= '0;
      idle_fired   <= 1'b0;
      idle_timeout <= 1'b0;
    end else if (change) begin
      idle_cnt     <= '0;
      idle_fired   <= 1'b0;
      idle_timeout <= 1'b0;
    end else if (idle_tick) begin
      if (idle_cnt == IW'(IDLE_TO - 1)) begin
        idle_cnt     <= '0;
        idle_fired   <= 1'b1;
        idle_timeout <= 1'b1;
      end else begin
        idle_cnt     <= idle_cnt + 1'b1;
        idle_timeout <= 1'b0;
      end
    end else begin
      idle_timeout <= 1'b0;
    end
  end

endmodule
